// File: rtl/press_decoder_if.sv
// Press decoder signal bundle: debounced toggle in, press events and count out.
// master is the debouncer/consumer side, slave is the decoder itself.
interface press_decoder_if #(
  parameter int CW = 8
);
  logic          tog;
  logic          press;
  logic          single_press;
  logic          double_press;
  logic [CW-1:0] press_count;
  logic          busy;

  modport master (
    output tog,
    input  press, single_press, double_press, press_count, busy
  );

  modport slave (
    input  tog,
    output press, single_press, double_press, press_count, busy
  );
endinterface

// File: rtl/press_decoder.sv
// Turns each debounced toggle into a press pulse, wrap-around count and single/double
// classification; outputs update 2 edges after tog is first sampled, no back-pressure.
module press_decoder #(
  parameter int WINDOW = 20,
  parameter int CW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  press_decoder_if.slave   bus
);

  localparam int TW = $clog2(WINDOW + 1);
  localparam logic [TW:0] W_LIM = (TW + 1)'(WINDOW);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic [1:0]      r_arm;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [TW:0]     w_tmr_inc;
  logic            r_press;
  logic            r_single;
  logic            r_double;
  logic            w_press_nxt;
  logic            w_single_nxt;
  logic            w_double_nxt;
  logic [CW-1:0]   r_count;
  logic            w_evt;

  // Events stay masked until the synchronizer has absorbed the level tog had at reset.
  assign w_evt     = (r_s2 ^ r_s3) && (r_arm == 2'd3);
  assign w_tmr_inc = {1'b0, r_timer} + {{TW{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_arm <= 2'd0;
    end else begin
      r_s1 <= bus.tog;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_arm != 2'd3) begin
        r_arm <= r_arm + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_press_nxt  = 1'b0;
    w_single_nxt = 1'b0;
    w_double_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (w_evt) begin
          w_press_nxt = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_timer_nxt = w_tmr_inc[TW-1:0];
        // An event on the timeout cycle is still a double; it takes priority.
        if (w_evt) begin
          w_press_nxt  = 1'b1;
          w_double_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else if (w_tmr_inc == W_LIM) begin
          w_single_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_press  <= 1'b0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_press  <= w_press_nxt;
      r_single <= w_single_nxt;
      r_double <= w_double_nxt;
      if (w_evt) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign bus.press        = r_press;
  assign bus.single_press = r_single;
  assign bus.double_press = r_double;
  assign bus.press_count  = r_count;
  assign bus.busy         = (r_state == WAIT);

endmodule
